crc_stream_engine: RTL and testbench
====================================

// Module: crc_stream_engine
// PURPOSE
//  Parametrised, byte-parallel CRC generator/checker; successor to the bit-serial 16-bit CRC LFSR.
//  Consumes a framed stream of DATA_W bits/beat (valid/ready), folds whole bytes MSB-first into the CRC.
//  Presents final CRC (or pass/fail in check mode) on a held output handshake.
//  Sits between the packet source and the framer/TX mux; reused on the RX side as checker.
// PARAMETERS
//  CRC_W   16      CRC width in bits (8..32)
//  POLY    16'h8005 generator polynomial, implicit x^CRC_W term omitted (default x^16+x^15+x^2+1)
//  INIT    16'h0000 register value loaded at start of frame
//  XOROUT  16'h0000 XOR applied to register to form crc_out
//  RESIDUE 16'h0000 register value after message+appended CRC that indicates a good frame
//  DATA_W  8       beat width; multiple of 8, 8..64
// PORTS
//  Clk        in   1          clock, all state rising-edge
//  R          in   1          synchronous active-high reset
//  mode_chk   in   1          0=generate, 1=check; sampled on SOF beat, held for the frame
//  in_valid   in   1          beat valid
//  in_ready   out  1          beat accepted when in_valid & in_ready
//  in_data    in   DATA_W     beat; byte lane DATA_W-1:DATA_W-8 is first on wire
//  in_sof     in   1          first beat of frame
//  in_eof     in   1          last beat of frame
//  in_keep    in   DATA_W/8   valid byte lanes on EOF beat, contiguous from MSB lane; ignored otherwise
//  crc_valid  out  1          result available
//  crc_ready  in   1          result consumed when crc_valid & crc_ready
//  crc_out    out  CRC_W      register ^ XOROUT
//  crc_ok     out  1          check mode: register == RESIDUE; 0 in generate mode
//  frame_err  out  1          one-cycle pulse: protocol violation (see below)
// BEHAVIOUR
//  Bit step: fb = crc[CRC_W-1] ^ d; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0); bytes MSB-bit first.
//  States IDLE, RUN, DONE. Reset: state=IDLE, crc reg=INIT, crc_valid=0, crc_out=INIT^XOROUT, crc_ok=0, frame_err=0.
//  in_ready = (state != DONE) | crc_ready  (combinational; allows back-to-back frames).
//  IDLE: accepted beat with in_sof -> load INIT, fold beat; eof ? DONE : RUN. Beat without sof -> dropped, frame_err.
//  RUN: accepted beat folds into reg; eof -> DONE. sof in RUN -> frame_err, restart from INIT with this beat.
//  sof & eof same beat -> single-beat frame, IDLE -> DONE directly.
//  EOF beat: only lanes with in_keep set fold; in_keep==0 on EOF -> treated as all lanes, frame_err.
//  Non-contiguous in_keep: lanes up to first cleared bit fold, frame_err.
//  Latency: EOF accepted in cycle N -> crc_valid=1 with final crc_out/crc_ok in cycle N+1.
//  DONE: crc_valid, crc_out, crc_ok held stable until crc_ready. On crc_ready: crc_valid drops next cycle
//   unless an sof beat is accepted that same cycle (-> RUN, or DONE again if also eof, new result N+1).
//  in_valid low mid-frame: hold reg, stay RUN, no timeout.
//  R in any state: immediate return to reset values next edge; partial frame discarded, no crc_valid.
//  All widths CRC_W unless noted; POLY/INIT/XOROUT/RESIDUE truncated to CRC_W.
// STRUCTURE
//  crc_pkg: state enum (IDLE/RUN/DONE), function crc_byte_step(crc, byte, poly) generic over CRC_W,
//   CRC16_BUYPASS_POLY=16'h8005, CRC16_CCITT_POLY=16'h1021 constants.
//  One sub-module: crc_lane_fold (combinational, folds DATA_W/8 bytes with keep mask), used once.
//  Top holds FSM, register, output hold and handshake; no other hierarchy.
// TESTING
//  1 Default params, DATA_W=8, gen mode, "123456789" one byte/beat, sof on '1', eof on '9' -> crc_out=16'hFEE8, crc_ok=0, one cycle after eof.
//  2 DATA_W=32, same 9 bytes as 3 beats, last in_keep=4'b1000 -> 16'hFEE8; POLY=16'h1021, INIT=16'hFFFF same msg -> 16'h29B1.
//  3 Check mode, DATA_W=8, "123456789",8'hFE,8'hE8 -> crc_ok=1; flip one bit of any byte -> crc_ok=0.
//  4 Hold crc_ready=0 10 cycles: crc_valid/crc_out stable, in_ready=0; raise crc_ready with next sof beat -> accepted same cycle, no bubble.
//  5 Beat without sof in IDLE -> frame_err pulse, no crc_valid; sof mid-RUN -> frame_err, result equals CRC of new frame only.
//  6 Assert R mid-frame after 4 bytes, then send "123456789" -> 16'hFEE8; crc_valid low throughout reset.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: shared state encoding, polynomial constants and the byte-step CRC helper
// for the CRC stream engine.
`default_nettype none

package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          CRC_MAX_W          = 32;
    localparam logic [15:0] CRC16_BUYPASS_POLY = 16'h8005;
    localparam logic [15:0] CRC16_CCITT_POLY   = 16'h1021;

    // Operands are MSB-aligned in a 32-bit word so one routine serves every CRC width.
    function automatic logic [CRC_MAX_W-1:0] crc_byte_step(
        input logic [CRC_MAX_W-1:0] crc,
        input logic [7:0]           data,
        input logic [CRC_MAX_W-1:0] poly
    );
        logic [CRC_MAX_W-1:0] c;
        logic                 fb;
        c = crc;
        for (int b = 7; b >= 0; b--) begin
            fb = c[CRC_MAX_W-1] ^ data[b];
            c  = {c[CRC_MAX_W-2:0], 1'b0} ^ (fb ? poly : '0);
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/crc_lane_fold.sv
// crc_lane_fold: combinational fold of up to DATA_W/8 byte lanes (MSB lane first)
// into a CRC, with EOF keep-mask sanitising and error flag.
`default_nettype none

module crc_lane_fold
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 16,
    parameter int               DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_BUYPASS_POLY)
) (
    input  logic [CRC_W-1:0]    i_crc,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [DATA_W/8-1:0] i_keep,
    input  logic                i_last,
    output logic [CRC_W-1:0]    o_crc,
    output logic                o_keep_err
);

    localparam int                   C_NB     = DATA_W / 8;
    localparam logic [CRC_MAX_W-1:0] C_POLY_A = CRC_MAX_W'(POLY) << (CRC_MAX_W - CRC_W);

    logic [C_NB-1:0]      w_en;
    logic                 w_run;
    logic [CRC_MAX_W-1:0] w_acc;

    always_comb begin
        w_en       = '1;
        w_run      = 1'b1;
        o_keep_err = 1'b0;
        // Only the EOF beat is trimmed; an empty mask there falls back to all lanes.
        if (i_last) begin
            if (i_keep == '0) begin
                o_keep_err = 1'b1;
            end else begin
                for (int l = C_NB - 1; l >= 0; l--) begin
                    w_run   = w_run & i_keep[l];
                    w_en[l] = w_run;
                end
                o_keep_err = (w_en != i_keep);
            end
        end

        w_acc                      = '0;
        w_acc[CRC_MAX_W-1 -: CRC_W] = i_crc;
        for (int l = C_NB - 1; l >= 0; l--) begin
            if (w_en[l]) begin
                w_acc = crc_byte_step(w_acc, i_data[l*8 +: 8], C_POLY_A);
            end
        end
        o_crc = w_acc[CRC_MAX_W-1 -: CRC_W];
    end

endmodule

`default_nettype wire

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: byte-parallel CRC generator/checker over a framed valid/ready
// stream, with a held result handshake. Rev 1.0
`default_nettype none

module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int          CRC_W   = 16,
    parameter logic [31:0] POLY    = 32'(CRC16_BUYPASS_POLY),
    parameter logic [31:0] INIT    = 32'h0000,
    parameter logic [31:0] XOROUT  = 32'h0000,
    parameter logic [31:0] RESIDUE = 32'h0000,
    parameter int          DATA_W  = 8
) (
    input  logic                Clk,
    input  logic                R,
    input  logic                mode_chk,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_sof,
    input  logic                in_eof,
    input  logic [DATA_W/8-1:0] in_keep,
    output logic                crc_valid,
    input  logic                crc_ready,
    output logic [CRC_W-1:0]    crc_out,
    output logic                crc_ok,
    output logic                frame_err
);

    localparam logic [CRC_W-1:0] C_POLY    = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] C_INIT    = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] C_XOROUT  = XOROUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] C_RESIDUE = RESIDUE[CRC_W-1:0];

    state_t           r_state;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] r_crc_out;
    logic             r_mode;
    logic             r_crc_valid;
    logic             r_crc_ok;
    logic             r_frame_err;

    logic             w_acc;
    logic             w_mode;
    logic             w_keep_err;
    logic [CRC_W-1:0] w_base;
    logic [CRC_W-1:0] w_fold;

    assign in_ready  = (r_state != DONE) | crc_ready;
    assign w_acc     = in_valid & in_ready;
    assign w_base    = in_sof ? C_INIT : r_crc;
    assign w_mode    = in_sof ? mode_chk : r_mode;

    assign crc_valid = r_crc_valid;
    assign crc_out   = r_crc_out;
    assign crc_ok    = r_crc_ok;
    assign frame_err = r_frame_err;

    crc_lane_fold #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (C_POLY)
    ) u_fold (
        .i_crc      (w_base),
        .i_data     (in_data),
        .i_keep     (in_keep),
        .i_last     (in_eof),
        .o_crc      (w_fold),
        .o_keep_err (w_keep_err)
    );

    always_ff @(posedge Clk) begin
        if (R) begin
            r_state     <= IDLE;
            r_crc       <= C_INIT;
            r_mode      <= 1'b0;
            r_crc_valid <= 1'b0;
            r_crc_out   <= C_INIT ^ C_XOROUT;
            r_crc_ok    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_state == DONE && crc_ready) begin
                r_state     <= IDLE;
                r_crc_valid <= 1'b0;
            end
            // An SOF beat accepted in DONE overrides the drop to IDLE above.
            if (w_acc) begin
                if (in_sof || r_state == RUN) begin
                    r_crc       <= w_fold;
                    r_mode      <= w_mode;
                    r_frame_err <= (in_sof && r_state == RUN) || (in_eof && w_keep_err);
                    if (in_eof) begin
                        r_state     <= DONE;
                        r_crc_valid <= 1'b1;
                        r_crc_out   <= w_fold ^ C_XOROUT;
                        r_crc_ok    <= w_mode && (w_fold == C_RESIDUE);
                    end else begin
                        r_state <= RUN;
                    end
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: directed checks of the CRC stream engine in 8-bit and
// 32-bit beat configurations against hand-computed CRC-16 values.
`default_nettype none

module tb_crc_stream_engine;

    logic        Clk = 1'b0;
    logic        R   = 1'b1;

    logic        a_mode = 1'b0, a_valid = 1'b0, a_sof = 1'b0, a_eof = 1'b0;
    logic        a_keep = 1'b1, a_crc_ready = 1'b1;
    logic [7:0]  a_data = 8'h00;
    logic        a_in_ready, a_crc_valid, a_crc_ok, a_frame_err;
    logic [15:0] a_crc_out;

    logic        b_valid = 1'b0, b_sof = 1'b0, b_eof = 1'b0;
    logic [31:0] b_data = 32'h0;
    logic [3:0]  b_keep = 4'hF;
    logic        b_in_ready, b_crc_valid, b_crc_ok, b_frame_err;
    logic [15:0] b_crc_out;
    logic        c_in_ready, c_crc_valid, c_crc_ok, c_frame_err;
    logic [15:0] c_crc_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    crc_stream_engine u_a (
        .Clk(Clk), .R(R), .mode_chk(a_mode), .in_valid(a_valid), .in_ready(a_in_ready),
        .in_data(a_data), .in_sof(a_sof), .in_eof(a_eof), .in_keep(a_keep),
        .crc_valid(a_crc_valid), .crc_ready(a_crc_ready), .crc_out(a_crc_out),
        .crc_ok(a_crc_ok), .frame_err(a_frame_err)
    );

    crc_stream_engine #(.DATA_W(32)) u_b (
        .Clk(Clk), .R(R), .mode_chk(1'b0), .in_valid(b_valid), .in_ready(b_in_ready),
        .in_data(b_data), .in_sof(b_sof), .in_eof(b_eof), .in_keep(b_keep),
        .crc_valid(b_crc_valid), .crc_ready(1'b1), .crc_out(b_crc_out),
        .crc_ok(b_crc_ok), .frame_err(b_frame_err)
    );

    crc_stream_engine #(.DATA_W(32), .POLY(32'h1021), .INIT(32'hFFFF)) u_c (
        .Clk(Clk), .R(R), .mode_chk(1'b0), .in_valid(b_valid), .in_ready(c_in_ready),
        .in_data(b_data), .in_sof(b_sof), .in_eof(b_eof), .in_keep(b_keep),
        .crc_valid(c_crc_valid), .crc_ready(1'b1), .crc_out(c_crc_out),
        .crc_ok(c_crc_ok), .frame_err(c_frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic s, input logic e);
        a_valid = 1'b1;
        a_data  = d;
        a_sof   = s;
        a_eof   = e;
        tick();
    endtask

    task automatic idle_a();
        a_valid = 1'b0;
        a_sof   = 1'b0;
        a_eof   = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic s, input logic e, input logic [3:0] k);
        b_valid = 1'b1;
        b_data  = d;
        b_sof   = s;
        b_eof   = e;
        b_keep  = k;
        tick();
        b_valid = 1'b0;
        b_sof   = 1'b0;
        b_eof   = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(a_crc_valid), 32'h0);
        chk("rst_out", 32'(a_crc_out), 32'h0000);
        chk("rst_ok", 32'(a_crc_ok), 32'h0);
        chk("rst_err", 32'(a_frame_err), 32'h0);
        chk("rst_c_out", 32'(c_crc_out), 32'hFFFF);
        R = 1'b0;
        chk("rst_ready", 32'(a_in_ready), 32'h1);

        // Generate mode, one byte per beat
        for (int i = 0; i < 9; i++) begin
            send_a(8'(i + 49), i == 0, i == 8);
            if (i == 7) chk("t1_pre_eof_valid", 32'(a_crc_valid), 32'h0);
        end
        idle_a();
        chk("t1_valid", 32'(a_crc_valid), 32'h1);
        chk("t1_out", 32'(a_crc_out), 32'hFEE8);
        chk("t1_ok", 32'(a_crc_ok), 32'h0);
        tick();
        chk("t1_drop", 32'(a_crc_valid), 32'h0);

        // 32-bit beats, partial EOF keep
        send_b(32'h31323334, 1'b1, 1'b0, 4'hF);
        send_b(32'h35363738, 1'b0, 1'b0, 4'hF);
        send_b(32'h39000000, 1'b0, 1'b1, 4'b1000);
        chk("t2_b_valid", 32'(b_crc_valid), 32'h1);
        chk("t2_b_out", 32'(b_crc_out), 32'hFEE8);
        chk("t2_c_out", 32'(c_crc_out), 32'h29B1);
        chk("t2_b_err", 32'(b_frame_err), 32'h0);
        tick();
        // Non-contiguous keep: only the MSB lane folds
        send_b(32'h31323334, 1'b1, 1'b0, 4'hF);
        send_b(32'h35363738, 1'b0, 1'b0, 4'hF);
        send_b(32'h39AABBCC, 1'b0, 1'b1, 4'b1010);
        chk("t2_nc_b_out", 32'(b_crc_out), 32'hFEE8);
        chk("t2_nc_c_out", 32'(c_crc_out), 32'h29B1);
        chk("t2_nc_err", 32'(b_frame_err), 32'h1);
        tick();
        chk("t2_nc_err_clr", 32'(b_frame_err), 32'h0);

        // Check mode: good frame then a corrupted one
        a_mode = 1'b1;
        for (int i = 0; i < 9; i++) send_a(8'(i + 49), i == 0, 1'b0);
        send_a(8'hFE, 1'b0, 1'b0);
        send_a(8'hE8, 1'b0, 1'b1);
        idle_a();
        chk("t3_good_valid", 32'(a_crc_valid), 32'h1);
        chk("t3_good_ok", 32'(a_crc_ok), 32'h1);
        tick();
        for (int i = 0; i < 9; i++) send_a((i == 4) ? 8'h34 : 8'(i + 49), i == 0, 1'b0);
        send_a(8'hFE, 1'b0, 1'b0);
        send_a(8'hE8, 1'b0, 1'b1);
        idle_a();
        chk("t3_bad_ok", 32'(a_crc_ok), 32'h0);
        tick();
        a_mode = 1'b0;

        // Result held while crc_ready is low, then back-to-back SOF
        a_crc_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_a(8'(i + 49), i == 0, i == 8);
        a_valid = 1'b1;
        a_data  = 8'h31;
        a_sof   = 1'b1;
        a_eof   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("t4_hold_valid", 32'(a_crc_valid), 32'h1);
            chk("t4_hold_out", 32'(a_crc_out), 32'hFEE8);
            chk("t4_hold_ready", 32'(a_in_ready), 32'h0);
            tick();
        end
        a_crc_ready = 1'b1;
        #1;
        chk("t4_ready_up", 32'(a_in_ready), 32'h1);
        tick();
        chk("t4_valid_drop", 32'(a_crc_valid), 32'h0);
        for (int i = 1; i < 9; i++) send_a(8'(i + 49), 1'b0, i == 8);
        idle_a();
        chk("t4_b2b_out", 32'(a_crc_out), 32'hFEE8);
        chk("t4_b2b_valid", 32'(a_crc_valid), 32'h1);
        tick();

        // Protocol errors
        send_a(8'h55, 1'b0, 1'b0);
        idle_a();
        chk("t5_nosof_err", 32'(a_frame_err), 32'h1);
        chk("t5_nosof_valid", 32'(a_crc_valid), 32'h0);
        tick();
        chk("t5_err_pulse", 32'(a_frame_err), 32'h0);
        chk("t5_idle_valid", 32'(a_crc_valid), 32'h0);
        send_a(8'h31, 1'b1, 1'b0);
        send_a(8'h32, 1'b0, 1'b0);
        send_a(8'h31, 1'b1, 1'b0);
        chk("t5_sof_run_err", 32'(a_frame_err), 32'h1);
        for (int i = 1; i < 9; i++) begin
            send_a(8'(i + 49), 1'b0, i == 8);
            if (i == 1) chk("t5_err_clr", 32'(a_frame_err), 32'h0);
        end
        idle_a();
        chk("t5_restart_out", 32'(a_crc_out), 32'hFEE8);
        tick();

        // Reset mid-frame
        for (int i = 0; i < 4; i++) send_a(8'(i + 49), i == 0, 1'b0);
        idle_a();
        R = 1'b1;
        tick();
        chk("t6_rst_valid0", 32'(a_crc_valid), 32'h0);
        tick();
        chk("t6_rst_valid1", 32'(a_crc_valid), 32'h0);
        chk("t6_rst_out", 32'(a_crc_out), 32'h0000);
        R = 1'b0;
        for (int i = 0; i < 9; i++) send_a(8'(i + 49), i == 0, i == 8);
        idle_a();
        chk("t6_out", 32'(a_crc_out), 32'hFEE8);
        chk("t6_valid", 32'(a_crc_valid), 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
